// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps pre/post spikes and wrap markers into a show-ahead FIFO.
// Optional `SPIKE_LOGGER_DROP_CNT_EN adds a saturating drop_count output that backs overflow.
module spike_event_logger #(
    parameter  int TS_WIDTH = 6,
    parameter  int DEPTH    = 8,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  spike_pre,
    input  logic                  spike_post,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [TS_WIDTH+2:0]   evt_data,
    output logic [CNT_W-1:0]      evt_count,
    output logic                  overflow
`ifdef SPIKE_LOGGER_DROP_CNT_EN
    ,
    output logic [7:0]            drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int EVT_W = TS_WIDTH + 3;

    logic [TS_WIDTH-1:0] ts_p0;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [EVT_W-1:0]    mem [DEPTH];

    logic                wrap;
    logic [2:0]          tag;
    logic                wr_req;
    logic                full;
    logic                do_pop;
    logic                do_push;
    logic                do_drop;
    logic [EVT_W-1:0]    wr_data;

    // Stage p0: event tagging from the live timestamp
    always_comb begin
        wrap    = enable && (ts_p0 == {TS_WIDTH{1'b1}});
        tag     = {wrap, spike_pre, spike_post};
        wr_req  = enable && !clear && (tag != 3'b000);
        wr_data = {tag, ts_p0};
        full    = (count == CNT_W'(DEPTH));
        do_pop  = !clear && (count != '0) && evt_ready;
        // A pop on a full FIFO frees the slot the concurrent push lands in.
        do_push = wr_req && (!full || do_pop);
        do_drop = wr_req && full && !do_pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_p0 <= '0;
        end else if (clear) begin
            ts_p0 <= '0;
        end else if (enable) begin
            ts_p0 <= ts_p0 + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Stage p1: storage holds data only; validity lives in count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef SPIKE_LOGGER_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (clear) begin
            drop_cnt <= '0;
        end else if (do_drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_count = drop_cnt;
    assign overflow   = (drop_cnt != 8'd0);
`else
    logic ovf_sticky;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
        end else if (clear) begin
            ovf_sticky <= 1'b0;
        end else if (do_drop) begin
            ovf_sticky <= 1'b1;
        end
    end

    assign overflow = ovf_sticky;
`endif

    // Stage p2: show-ahead head, forced to zero when empty
    assign evt_valid = (count != '0);
    assign evt_count = count;
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_spike_event_logger.sv
// Scoreboard bench for spike_event_logger: a queue model of the FIFO is updated per stimulus
// cycle and every output is compared after each clock edge, plus fixed-value checks.
module tb_spike_event_logger;

    localparam int TS_WIDTH = 6;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                enable;
    logic                clear;
    logic                spike_pre;
    logic                spike_post;
    logic                evt_valid;
    logic                evt_ready;
    logic [TS_WIDTH+2:0] evt_data;
    logic [CNT_W-1:0]    evt_count;
    logic                overflow;
`ifdef SPIKE_LOGGER_DROP_CNT_EN
    logic [7:0]          drop_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];
    logic [5:0] m_ts;
    logic       m_ovf;
    int         m_drop;

    always #5 clk = ~clk;

    spike_event_logger #(.TS_WIDTH(TS_WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .spike_pre  (spike_pre),
        .spike_post (spike_post),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_count  (evt_count),
        .overflow   (overflow)
`ifdef SPIKE_LOGGER_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ts   = '0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, 32'(evt_valid), 32'(sb.size() != 0));
        chk({tag, ".count"}, 32'(evt_count), 32'(sb.size()));
        chk({tag, ".data"},  32'(evt_data),  (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
        chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    endtask

    // One clock of stimulus; model updated with the pre-edge state, outputs compared after the edge.
    task automatic step(input logic pre, input logic post, input logic rdy,
                        input logic en, input logic clr);
        logic       pop;
        logic [2:0] tag;
        logic [8:0] dummy;
        @(negedge clk);
        spike_pre  = pre;
        spike_post = post;
        evt_ready  = rdy;
        enable     = en;
        clear      = clr;
        if (clr) begin
            model_reset();
        end else begin
            pop = (sb.size() != 0) && rdy;
            tag = {en && (m_ts == 6'h3F), pre, post};
            if (pop) dummy = sb.pop_front();
            if (en && (tag != 3'b000)) begin
                if (sb.size() < DEPTH) begin
                    sb.push_back({tag, m_ts});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
            if (en) m_ts = m_ts + 6'd1;
        end
        @(posedge clk);
        #1;
        compare_all("cyc");
    endtask

    task automatic idle_until(input logic [5:0] target);
        for (int k = 0; k < 70 && m_ts != target; k++) step(0, 0, 0, 1, 0);
        chk("idle_bound", 32'(m_ts), 32'(target));
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2 && sb.size() != 0; k++) step(0, 0, 1, 1, 0);
        chk("drain_empty", 32'(evt_count), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        clear      = 1'b0;
        spike_pre  = 1'b0;
        spike_post = 1'b0;
        evt_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(evt_valid), 32'd0);
        chk("rst.data",  32'(evt_data),  32'd0);
        chk("rst.count", 32'(evt_count), 32'd0);
        chk("rst.ovf",   32'(overflow),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // single spike at timestamp 5
        idle_until(6'd5);
        step(1, 0, 0, 1, 0);
        chk("single.data",  32'(evt_data),  32'h085);
        chk("single.count", 32'(evt_count), 32'd1);
        drain();

        // coincident spikes at timestamp 9 with ready held high
        idle_until(6'd9);
        step(1, 1, 1, 1, 0);
        chk("coinc.data", 32'(evt_data), 32'h0C9);
        step(0, 0, 1, 1, 0);
        chk("coinc.valid", 32'(evt_valid), 32'd0);

        // wrap marker alone, then wrap coinciding with a post spike
        idle_until(6'd63);
        step(0, 0, 0, 1, 0);
        chk("wrap.data", 32'(evt_data), 32'h13F);
        step(0, 0, 1, 1, 0);
        idle_until(6'd63);
        chk("wrap.quiet", 32'(evt_count), 32'd0);
        step(0, 1, 0, 1, 0);
        chk("wrap_post.data",  32'(evt_data),  32'h17F);
        chk("wrap_post.count", 32'(evt_count), 32'd1);
        drain();

        // fill to full, overflow, then push+pop while full
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        for (int i = 1; i <= 9; i++) step(1, 0, 0, 1, 0);
        chk("full.count", 32'(evt_count), 32'd8);
        chk("full.ovf",   32'(overflow),  32'd1);
        chk("full.head",  32'(evt_data),  32'h081);
        idle_until(6'd12);
        step(0, 1, 1, 1, 0);
        chk("fullpp.count", 32'(evt_count), 32'd8);
        chk("fullpp.head",  32'(evt_data),  32'h082);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 1, 0);
        chk("fullpp.tail", 32'(evt_data), 32'h04C);
        drain();
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // clear beats a concurrent spike; enable=0 freezes everything
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        chk("clear.count", 32'(evt_count), 32'd0);
        chk("clear.ovf",   32'(overflow),  32'd0);
        step(1, 0, 0, 1, 0);
        chk("clear.ts0", 32'(evt_data), 32'h080);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        chk("dis.count", 32'(evt_count), 32'd1);
        step(0, 1, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("dis.ts_hold", 32'(evt_data), 32'h041);
        drain();

        // asynchronous reset between edges with 4 entries queued
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
        chk("pre_rst.count", 32'(evt_count), 32'd4);
        @(negedge clk);
        spike_pre = 1'b0;
        enable    = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.valid", 32'(evt_valid), 32'd0);
        chk("arst.count", 32'(evt_count), 32'd0);
        chk("arst.data",  32'(evt_data),  32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 1, 0, 1, 0);
        chk("post_rst.data", 32'(evt_data), 32'h040);
        drain();

`ifdef SPIKE_LOGGER_DROP_CNT_EN
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < DEPTH + 10; i++) step(1, 0, 0, 1, 0);
        chk("drop.count", 32'(drop_count), 32'(m_drop));
        chk("drop.ten",   32'(drop_count), 32'd10);
        step(0, 0, 0, 1, 1);
        chk("drop.clear", 32'(drop_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
